// File: rtl/bus_dma_master.sv
// bus_dma_master: bus initiator that copies a block of bytes from one address range to another
module bus_dma_master #(
    parameter logic [7:0] IDLE_ADDR = 8'hFF
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic [7:0] SRC_ADDR,
    input  logic [7:0] DST_ADDR,
    input  logic [7:0] LEN,
    output logic       BUSY,
    output logic       DONE,
    output logic       BUS_REQ,
    input  logic       BUS_GNT,
    output logic [7:0] BUS_ADDR,
    output logic       BUS_WE,
    inout  wire  [7:0] BUS_DATA
);
    typedef enum logic [2:0] {IDLE, REQ, RD_ADDR, RD_TURN, WR, FIN} state_t;
    state_t     r_state;
    logic [7:0] r_src, r_dst, r_cnt, r_buf, r_addr;
    logic       r_busy, r_done, r_req, r_we;
    assign BUSY     = r_busy;
    assign DONE     = r_done;
    assign BUS_REQ  = r_req;
    assign BUS_ADDR = r_addr;
    assign BUS_WE   = r_we;
    assign BUS_DATA = r_we ? r_buf : 8'hzz;
    // Copy sequencer: outputs are registered together with the state they belong to
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
            r_src   <= 8'h00;
            r_dst   <= 8'h00;
            r_cnt   <= 8'h00;
            r_buf   <= 8'h00;
            r_addr  <= IDLE_ADDR;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (START) begin
                    r_src  <= SRC_ADDR;
                    r_dst  <= DST_ADDR;
                    r_cnt  <= LEN;
                    r_busy <= 1'b1;
                    if (LEN != 8'd0) begin
                        r_req   <= 1'b1;
                        r_state <= REQ;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= FIN;
                    end
                end
                REQ: if (BUS_GNT) begin
                    r_addr  <= r_src;
                    r_state <= RD_ADDR;
                end
                RD_ADDR: begin
                    r_addr  <= IDLE_ADDR;
                    r_state <= RD_TURN;
                end
                RD_TURN: begin
                    r_buf   <= BUS_DATA;
                    r_addr  <= r_dst;
                    r_we    <= 1'b1;
                    r_state <= WR;
                end
                WR: begin
                    r_src <= r_src + 8'd1;
                    r_dst <= r_dst + 8'd1;
                    r_cnt <= r_cnt - 8'd1;
                    r_we  <= 1'b0;
                    if (r_cnt == 8'd1) begin
                        r_addr  <= IDLE_ADDR;
                        r_done  <= 1'b1;
                        r_state <= FIN;
                    end else begin
                        r_addr  <= r_src + 8'd1;
                        r_state <= RD_ADDR;
                    end
                end
                FIN: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_req   <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/bus_dma_master.md
Name: bus_dma_master

Overview:
- Bus initiator that copies a block of bytes from one address range to another over the shared 8-bit CPU data bus.
- Counterpart of the bus responders (RAM, peripherals): it drives BUS_ADDR and BUS_WE, samples read data from BUS_DATA, and drives BUS_DATA on writes.
- Arbitrates with the CPU through a request/grant pair. The top level muxes BUS_ADDR/BUS_WE by BUS_GNT.

Parameters:
- IDLE_ADDR, 8'hFF, address driven whenever the master is not addressing a target; no responder decodes it.

Ports:
- CLK  in  1  system clock, rising edge
- RESET  in  1  synchronous, active-high reset
- START  in  1  one-cycle pulse; launches a copy when idle
- SRC_ADDR  in  8  first source address, latched on START
- DST_ADDR  in  8  first destination address, latched on START
- LEN  in  8  byte count, latched on START; 0 = no transfer
- BUSY  out  1  high from accepted START until DONE
- DONE  out  1  one-cycle completion pulse
- BUS_REQ  out  1  bus request to arbiter
- BUS_GNT  in  1  bus grant from arbiter
- BUS_ADDR  out  8  bus address
- BUS_WE  out  1  bus write enable
- BUS_DATA  inout  8  shared data bus; driven only in WR cycles, else 8'hZZ

Behaviour:
- Bus protocol:
  - Write: address, WE=1 and data are valid in the same cycle; the responder captures at the closing rising edge.
  - Read: a responder addressed with WE=0 in cycle N drives BUS_DATA during cycle N+1. The master samples BUS_DATA at the edge ending N+1.
- Reset (synchronous) values: BUSY=0, DONE=0, BUS_REQ=0, BUS_ADDR=IDLE_ADDR, BUS_WE=0, BUS_DATA=Z. Internal counters are cleared and the FSM goes to IDLE.
- Reset mid-transfer: abort immediately, no DONE pulse; the write in progress on that edge is lost.
- FSM states: IDLE, REQ, RD_ADDR, RD_TURN, WR, FIN.
- IDLE:
  - On START with LEN!=0: latch SRC/DST/LEN into src_ptr/dst_ptr/count, BUSY=1, go to REQ.
  - On START with LEN=0: go to FIN; no bus request, no bus cycles.
  - START while BUSY=1 is ignored.
- REQ: BUS_REQ=1; wait until BUS_GNT=1, then go to RD_ADDR.
- RD_ADDR: BUS_ADDR=src_ptr, BUS_WE=0 -> RD_TURN.
- RD_TURN: BUS_ADDR=IDLE_ADDR, BUS_WE=0 (so no responder drives during WR); capture BUS_DATA into data_buf at end of cycle -> WR.
- WR:
  - BUS_ADDR=dst_ptr, BUS_WE=1, BUS_DATA=data_buf.
  - At end of cycle: src_ptr+1, dst_ptr+1 (mod 256), count-1.
  - If count was 1, go to FIN; else go to RD_ADDR.
- FIN: DONE=1 for exactly one cycle, BUSY=0 and BUS_REQ=0 from the next cycle, return to IDLE. BUSY is still 1 during the FIN cycle.
- Throughput: exactly 3 cycles per byte once granted. Total = 1 (REQ, if GNT already high) + 3*LEN + 1 (FIN).
- BUS_REQ stays high from REQ through the last WR. The arbiter must not revoke BUS_GNT while BUS_REQ=1; a GNT drop mid-transfer is ignored.
- Wrap-around: pointers wrap 8'hFF->8'h00 silently.
- Overlapping ranges are copied strictly forward, byte by byte, with no hazard handling.
- BUS_DATA is never driven outside WR, including during reset and in all non-WR states.
- START coinciding with RESET: RESET wins.

Test Plan:
- Basic copy: RAM[0x10..0x13]=AA,BB,CC,DD; START SRC=0x10 DST=0x40 LEN=4, GNT tied 1 -> RAM[0x40..0x43]=AA,BB,CC,DD; DONE pulses 14 cycles after START; BUS_WE high exactly 4 cycles.
- Zero length: START LEN=0 -> DONE one cycle later; BUS_REQ, BUS_WE never asserted.
- Grant delay: GNT held 0 for 10 cycles after START -> BUS_ADDR stays 0xFF, BUS_WE=0, BUS_REQ=1 throughout; the copy completes normally after GNT rises.
- Wrap: SRC=0xFE DST=0x7E LEN=3 (bench RAM responds to full range except 0xFF) -> BUS_ADDR read sequence 0xFE,0xFF,0x00; writes to 0x7E,0x7F,0x80.
- Reset mid-copy: LEN=8, assert RESET after the 3rd WR -> only 3 destination bytes written; all outputs at reset values the next cycle; no DONE.
- Bus discipline: monitor BUS_DATA over all tests -> master drives only in WR cycles; no contention with the RAM model (never both driving).
